// File: rtl/pes_checksum_checker_if.sv
// Stream-in / result-out bundle for the pes checksum checker.
// The master side feeds words and consumes results; the checker is the slave.
interface pes_checksum_checker_if #(
  parameter int CNT_W = 7
);
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic             res_ok;
  logic             res_len_err;
  logic [15:0]      res_sum;
  logic [CNT_W-1:0] res_words;

  modport master (
    output in_data, in_valid, in_last, abort, res_ready,
    input  in_ready, res_valid, res_ok, res_len_err, res_sum, res_words
  );

  modport slave (
    input  in_data, in_valid, in_last, abort, res_ready,
    output in_ready, res_valid, res_ok, res_len_err, res_sum, res_words
  );
endinterface

// File: rtl/pes_checksum_checker.sv
// Receive-side verifier for the 16-bit one's-complement pes checksum.
// Folds each packet's words with end-around carry and holds one result per packet.
module pes_checksum_checker #(
  parameter int MAX_WORDS = 64,
  parameter int CNT_W     = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pes_checksum_checker_if.slave   bus
);

  typedef enum logic [0:0] {
    S_COLLECT = 1'b0,
    S_RESULT  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(2);

  state_t           state_q,       state_d;
  logic [15:0]      acc_q,         acc_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic             res_ok_q,      res_ok_d;
  logic             res_len_err_q, res_len_err_d;
  logic [15:0]      res_sum_q,     res_sum_d;
  logic [CNT_W-1:0] res_words_q,   res_words_d;

  logic [16:0]      s17;
  logic [15:0]      folded;
  logic [CNT_W-1:0] cnt_inc;
  logic             len_err;
  logic             accept;

  assign accept = bus.in_valid && (state_q == S_COLLECT);

  // The folded value cannot carry a second time: acc + w <= 0x1FFFE, so
  // low half + carry <= 0xFFFF.
  always_comb begin
    s17     = {1'b0, acc_q} + {1'b0, bus.in_data};
    folded  = s17[15:0] + {15'd0, s17[16]};
    cnt_inc = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);
    len_err = (cnt_inc < CNT_MIN) || (cnt_inc > CNT_MAX);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a signal unassigned and infer a latch.
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    res_ok_d      = res_ok_q;
    res_len_err_d = res_len_err_q;
    res_sum_d     = res_sum_q;
    res_words_d   = res_words_q;

    unique case (state_q)
      S_COLLECT: begin
        if (bus.abort) begin
          // abort outranks a same-cycle word, even the checksum word
          acc_d = '0;
          cnt_d = '0;
        end else if (accept) begin
          if (bus.in_last) begin
            state_d       = S_RESULT;
            res_sum_d     = folded;
            res_words_d   = cnt_inc;
            res_len_err_d = len_err;
            res_ok_d      = (folded == 16'hFFFF) && !len_err;
            acc_d         = '0;
            cnt_d         = '0;
          end else begin
            acc_d = folded;
            cnt_d = cnt_inc;
          end
        end
      end
      S_RESULT: begin
        if (bus.res_ready) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_COLLECT;
      acc_q         <= '0;
      cnt_q         <= '0;
      res_ok_q      <= 1'b0;
      res_len_err_q <= 1'b0;
      res_sum_q     <= '0;
      res_words_q   <= '0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      res_ok_q      <= res_ok_d;
      res_len_err_q <= res_len_err_d;
      res_sum_q     <= res_sum_d;
      res_words_q   <= res_words_d;
    end
  end

  assign bus.in_ready    = (state_q == S_COLLECT);
  assign bus.res_valid   = (state_q == S_RESULT);
  assign bus.res_ok      = res_ok_q;
  assign bus.res_len_err = res_len_err_q;
  assign bus.res_sum     = res_sum_q;
  assign bus.res_words   = res_words_q;

endmodule

// File: tb/tb_pes_checksum_checker.sv
// Self-checking bench for pes_checksum_checker: directed scenarios plus
// randomized packets compared against a whole-packet arithmetic model.
module tb_pes_checksum_checker;

  localparam int MAX_WORDS = 64;
  localparam int CNT_W     = 7;
  localparam int TIMEOUT   = 200;

  typedef logic [15:0] word_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  pes_checksum_checker_if #(.CNT_W(CNT_W)) bus ();

  pes_checksum_checker #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: sum the whole packet as an integer, then fold carries back in.
  function automatic logic [15:0] fold_sum(input word_q_t q);
    longint s = 0;
    foreach (q[i]) s += longint'(q[i]);
    while ((s >> 16) != 0) s = (s & 64'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  function automatic void model(input word_q_t q, output logic [15:0] sum,
                                output logic [CNT_W-1:0] words,
                                output logic len_err, output logic ok);
    int n = q.size();
    sum     = fold_sum(q);
    words   = CNT_W'((n > MAX_WORDS + 1) ? MAX_WORDS + 1 : n);
    len_err = (n < 2) || (n > MAX_WORDS);
    ok      = (sum == 16'hFFFF) && !len_err;
  endfunction

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.abort    = 1'b0;
    bus.in_data  = '0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [15:0] w, input logic last, input logic ab);
    int n = 0;
    bus.in_data  = w;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    bus.abort    = ab;
    while (!bus.in_ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_word_timeout: in_ready stuck at %b, required 1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    drive_idle();
  endtask

  task automatic send_packet(input word_q_t q);
    foreach (q[i]) send_word(q[i], (i == q.size() - 1), 1'b0);
  endtask

  // Entered at the negedge right after the last-word edge.
  task automatic expect_result(input string name, input word_q_t q, input int hold);
    logic [15:0]      es;
    logic [CNT_W-1:0] ew;
    logic             el, eo;
    logic [CNT_W+19:0] exp_vec, act_vec;
    model(q, es, ew, el, eo);
    exp_vec = {1'b1, 1'b0, eo, el, es, ew};
    for (int c = 0; c <= hold; c++) begin
      act_vec = {bus.res_valid, bus.in_ready, bus.res_ok, bus.res_len_err, bus.res_sum, bus.res_words};
      tests_run++;
      if (act_vec !== exp_vec) begin
        tests_failed++;
        $display("FAIL %s cycle %0d: valid/rdy/ok/lerr/sum/words got %b/%b/%b/%b/%h/%0d required 1/0/%b/%b/%h/%0d",
                 name, c, bus.res_valid, bus.in_ready, bus.res_ok, bus.res_len_err,
                 bus.res_sum, bus.res_words, eo, el, es, ew);
      end
      if (c < hold) @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s_release: res_valid/in_ready got %b/%b required 0/1",
               name, bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.res_valid, bus.in_ready, bus.res_ok, bus.res_len_err, bus.res_sum, bus.res_words}
        !== {1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, CNT_W'(0)}) begin
      tests_failed++;
      $display("FAIL reset: valid/rdy/ok/lerr/sum/words got %b/%b/%b/%b/%h/%0d required 0/1/0/0/0000/0",
               bus.res_valid, bus.in_ready, bus.res_ok, bus.res_len_err, bus.res_sum, bus.res_words);
    end
  endtask

  task automatic test_known_vectors();
    word_q_t p1 = '{16'h9D2D, 16'hC3D5, 16'h9EFC};
    word_q_t p2 = '{16'h0000, 16'h0000, 16'hFFFF};
    word_q_t p3 = '{16'h9D2D, 16'hC3D5, 16'h9EFD};
    word_q_t p4 = '{16'h0000, 16'h0000};
    send_packet(p1);
    tests_run++;
    if (bus.res_sum !== 16'hFFFF || bus.res_ok !== 1'b1 || bus.res_words !== CNT_W'(3)) begin
      tests_failed++;
      $display("FAIL known_p1: sum/ok/words got %h/%b/%0d required ffff/1/3",
               bus.res_sum, bus.res_ok, bus.res_words);
    end
    expect_result("known_p1", p1, 0);
    send_packet(p2);
    expect_result("known_p2", p2, 0);
    send_packet(p3);
    expect_result("known_p3_carry", p3, 0);
    send_packet(p4);
    tests_run++;
    if (bus.res_sum !== 16'h0000 || bus.res_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL known_zero_sum: sum/ok got %h/%b required 0000/0", bus.res_sum, bus.res_ok);
    end
    expect_result("known_zero_sum", p4, 0);
  endtask

  task automatic test_hold();
    word_q_t p = '{16'h1234, 16'h0F0F};
    word_q_t p2;
    logic [15:0] es;
    logic [CNT_W-1:0] ew;
    logic el, eo;
    p.push_back(~fold_sum(p));
    model(p, es, ew, el, eo);
    send_packet(p);
    bus.in_data  = 16'hABCD;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if ({bus.res_valid, bus.in_ready, bus.res_ok, bus.res_len_err, bus.res_sum, bus.res_words}
          !== {1'b1, 1'b0, eo, el, es, ew}) begin
        tests_failed++;
        $display("FAIL hold cycle %0d: valid/rdy/ok/sum/words got %b/%b/%b/%h/%0d required 1/0/%b/%h/%0d",
                 c, bus.res_valid, bus.in_ready, bus.res_ok, bus.res_sum, bus.res_words, eo, es, ew);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    // ABCD must have been taken exactly once, after the result left.
    p2 = '{16'hABCD, 16'h1111, 16'h2222};
    send_word(16'h1111, 1'b0, 1'b0);
    send_word(16'h2222, 1'b1, 1'b0);
    expect_result("hold_followup", p2, 0);
  endtask

  task automatic test_abort();
    word_q_t b = '{16'h0102, 16'h0304};
    word_q_t d = '{16'h7777, 16'h8888, 16'h0001};
    word_q_t e = '{16'h4444, 16'h5555};
    b.push_back(~fold_sum(b));
    send_word(16'hDEAD, 1'b0, 1'b0);
    send_word(16'hBEEF, 1'b0, 1'b0);
    send_word(16'h1234, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL abort_last cycle %0d: res_valid/in_ready got %b/%b required 0/1",
                 c, bus.res_valid, bus.in_ready);
      end
      @(negedge clk);
    end
    send_packet(b);
    expect_result("abort_then_b", b, 0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    send_word(16'hFFFF, 1'b0, 1'b0);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    send_packet(d);
    expect_result("abort_mid_then_d", d, 0);
    send_packet(e);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    expect_result("abort_in_result", e, 1);
  endtask

  task automatic test_overlength();
    word_q_t q;
    word_q_t one = '{16'hFFFF};
    for (int i = 0; i < MAX_WORDS - 1; i++) q.push_back(16'($urandom));
    q.push_back(~fold_sum(q));
    send_packet(q);
    expect_result("len_max_ok", q, 0);
    q.delete();
    for (int i = 0; i < MAX_WORDS; i++) q.push_back(16'($urandom));
    q.push_back(~fold_sum(q));
    send_packet(q);
    expect_result("len_max_plus1", q, 0);
    q.delete();
    for (int i = 0; i < MAX_WORDS + 3; i++) q.push_back(16'($urandom));
    send_packet(q);
    tests_run++;
    if (bus.res_words !== CNT_W'(MAX_WORDS + 1) || bus.res_len_err !== 1'b1 || bus.res_ok !== 1'b0) begin
      tests_failed++;
      $display("FAIL overlength: words/lerr/ok got %0d/%b/%b required %0d/1/0",
               bus.res_words, bus.res_len_err, bus.res_ok, MAX_WORDS + 1);
    end
    expect_result("overlength", q, 0);
    send_packet(one);
    expect_result("single_word", one, 0);
  endtask

  task automatic test_reset_mid();
    word_q_t p = '{16'hAAAA, 16'h1357};
    p.push_back(~fold_sum(p));
    send_word(16'h5A5A, 1'b0, 1'b0);
    send_word(16'h0F0F, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_packet(p);
    expect_result("reset_mid_packet", p, 0);
    send_packet(p);
    tests_run++;
    if (bus.res_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_pre_result: res_valid got %b required 1", bus.res_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.res_sum !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid_result: res_valid/res_sum got %b/%h required 0/0000",
               bus.res_valid, bus.res_sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_packet(p);
    expect_result("reset_then_clean", p, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 30; k++) begin
      word_q_t q;
      int len = $urandom_range(2, 12);
      for (int i = 0; i < len - 1; i++) q.push_back(16'($urandom));
      if ($urandom_range(0, 1) == 1) q.push_back(~fold_sum(q));
      else                           q.push_back(16'($urandom));
      foreach (q[i]) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_word(q[i], (i == q.size() - 1), 1'b0);
      end
      expect_result($sformatf("random_%0d", k), q, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    bus.res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      word_q_t q = '{16'($urandom), 16'($urandom)};
      logic [15:0] es;
      logic [CNT_W-1:0] ew;
      logic el, eo;
      q.push_back(~fold_sum(q));
      model(q, es, ew, el, eo);
      send_packet(q);
      tests_run++;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_sum !== es || bus.res_ok !== eo) begin
        tests_failed++;
        $display("FAIL b2b_%0d: valid/rdy/sum/ok got %b/%b/%h/%b required 1/0/%h/%b",
                 k, bus.res_valid, bus.in_ready, bus.res_sum, bus.res_ok, es, eo);
      end
    end
    @(negedge clk);
    tests_run++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_drain: res_valid/in_ready got %b/%b required 0/1", bus.res_valid, bus.in_ready);
    end
    bus.res_ready = 1'b0;
  endtask

  initial begin
    drive_idle();
    bus.res_ready = 1'b0;
    test_reset();
    test_known_vectors();
    test_hold();
    test_abort();
    test_overlength();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
